spike_motor_decoder: RTL and testbench
======================================

SPIKE_MOTOR_DECODER -- requirements
Module: spike_motor_decoder

Interface
REQ-001 SHALL have parameter WIN_LEN, default 256: number of enabled cycles per counting window (>=2).
REQ-002 SHALL have parameter CW, default 9: width of each spike counter and rate output.
REQ-003 SHALL have parameter DEADBAND, default 4: maximum |left-right| rate difference still decoded as FORWARD.
REQ-004 SHALL have parameter MIN_RATE, default 2: below this on both channels, decode STOP.
REQ-005 SHALL have port clk  input  1  single clock, all logic on its rising edge.
REQ-006 SHALL have port rst  input  1  synchronous, active-low reset.
REQ-007 SHALL have port en  input  1  count enable; window timer and counters advance only when 1.
REQ-008 SHALL have port spike_left  input  1  left excitatory neuron output spike, one per cycle max.
REQ-009 SHALL have port spike_right  input  1  right excitatory neuron output spike.
REQ-010 SHALL have port cmd_ready  input  1  downstream motor controller accepts the result.
REQ-011 SHALL have port cmd_valid  output  1  result available.
REQ-012 SHALL have port cmd  output  2  00 STOP, 01 LEFT, 10 RIGHT, 11 FORWARD.
REQ-013 SHALL have port left_rate  output  CW  left spike count of the reported window.
REQ-014 SHALL have port right_rate  output  CW  right spike count of the reported window.
REQ-015 SHALL have port overrun  output  1  sticky: a result was replaced before acceptance.

Function
REQ-016 SHALL implement FSM states IDLE, COUNT, EVAL, OUT.
REQ-017 SHALL move IDLE->COUNT on the first cycle with en=1; that cycle counts as window cycle 0.
REQ-018 SHALL increment the left/right counter on each cycle with en=1 and the respective spike=1, saturating at 2^CW-1.
REQ-019 SHALL hold the window timer and counters unchanged on cycles with en=0, in any state.
REQ-020 SHALL, on the WIN_LEN-th enabled cycle (spikes of that cycle included), snapshot both counters, clear counters and timer, and enter EVAL.
REQ-021 SHALL keep counting the next window continuously in EVAL and OUT; no enabled cycle is lost between windows.
REQ-022 SHALL in EVAL (one cycle) register left_rate/right_rate from the snapshot and register cmd by priority: both rates < MIN_RATE -> STOP; |L-R| <= DEADBAND -> FORWARD; L > R -> LEFT; else RIGHT.
REQ-023 SHALL compute |L-R| at CW+1 bits, signed, without overflow.
REQ-024 SHALL assert cmd_valid from the cycle after EVAL (two cycles after the window-ending cycle) and enter OUT.
REQ-025 SHALL hold cmd, left_rate, right_rate and cmd_valid stable in OUT until a cycle with cmd_valid=1 and cmd_ready=1; then cmd_valid drops next cycle and state returns to COUNT.
REQ-026 SHALL, if a window ends while in OUT and no handshake occurs that cycle, set overrun=1 and enter EVAL, replacing the pending result with the new one (cmd_valid stays 1).
REQ-027 SHALL, if a handshake and a window end occur in the same cycle, not set overrun, and go to EVAL.
REQ-028 SHALL hold overrun at 1 until reset.

Reset
REQ-029 SHALL, on any rising edge with rst=0, including mid-window or in OUT, clear counters, timer, snapshot, left_rate, right_rate, cmd (00), cmd_valid, overrun, and enter IDLE.
REQ-030 SHALL ignore en, spikes and cmd_ready during a cycle with rst=0.

Verification (WIN_LEN=16, CW=9, DEADBAND=4, MIN_RATE=2 unless stated)
REQ-031 SHALL test reset: rst=0 for 2 cycles with spikes toggling -> all outputs 0, no cmd_valid for 17 cycles after rst=1, en=1, no spikes -> then STOP.
REQ-032 SHALL test LEFT: en=1, spike_left=1 for 16 cycles, spike_right=0 -> cmd_valid 2 cycles after window end, left_rate=16, right_rate=0, cmd=01.
REQ-033 SHALL test FORWARD/RIGHT: window with L=5,R=9 -> FORWARD; window with L=3,R=8 -> RIGHT; window with L=1,R=1 -> STOP.
REQ-034 SHALL test handshake/overrun: cmd_ready=0 across two windows (L=16 then R=16) -> overrun=1, outputs switch to cmd=10, right_rate=16; cmd_ready=1 -> cmd_valid drops next cycle, overrun stays 1.
REQ-035 SHALL test en gating: en=0 for 10 cycles mid-window with spikes active -> window ends 10 cycles later, rates exclude gated spikes.
REQ-036 SHALL test saturation and mid-operation reset: CW=4, spike_left=1 for 16 cycles -> left_rate=15; rst=0 in OUT -> cmd_valid=0 next cycle, state IDLE.

Source files
------------

// File: rtl/spike_motor_decoder.sv
// Spike-rate motor decoder: counts left/right spikes per window
// and turns the two rates into a STOP/LEFT/RIGHT/FORWARD command.
module spike_motor_decoder #(
  parameter int WIN_LEN  = 256,
  parameter int CW       = 9,
  parameter int DEADBAND = 4,
  parameter int MIN_RATE = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          spike_left,
  input  logic          spike_right,
  input  logic          cmd_ready,
  output logic          cmd_valid,
  output logic [1:0]    cmd,
  output logic [CW-1:0] left_rate,
  output logic [CW-1:0] right_rate,
  output logic          overrun
);

  localparam int TW = $clog2(WIN_LEN);
  localparam logic [TW-1:0] LAST = TW'(WIN_LEN - 1);
  localparam logic [CW-1:0] MAXC = '1;

  localparam logic [1:0] C_STOP  = 2'b00;
  localparam logic [1:0] C_LEFT  = 2'b01;
  localparam logic [1:0] C_RIGHT = 2'b10;
  localparam logic [1:0] C_FWD   = 2'b11;

  typedef enum logic [1:0] {IDLE, COUNT, EVAL, OUT} state_e;

  state_e state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [CW-1:0] cnt_l_q, cnt_l_d;
  logic [CW-1:0] cnt_r_q, cnt_r_d;
  logic [CW-1:0] snap_l_q, snap_l_d;
  logic [CW-1:0] snap_r_q, snap_r_d;
  logic [CW-1:0] left_rate_q, left_rate_d;
  logic [CW-1:0] right_rate_q, right_rate_d;
  logic [1:0]    cmd_q, cmd_d;
  logic          cmd_valid_q, cmd_valid_d;
  logic          overrun_q, overrun_d;

  logic          win_end;
  logic          hs;
  logic [CW-1:0] nxt_l, nxt_r;
  logic signed [CW:0] diff;
  logic [CW:0]   abs_diff;
  logic [1:0]    dec_cmd;

  assign hs = cmd_valid_q && cmd_ready;

  // Window timer and saturating spike counters; run in every state.
  always_comb begin
    timer_d = timer_q;
    cnt_l_d = cnt_l_q;
    cnt_r_d = cnt_r_q;
    snap_l_d = snap_l_q;
    snap_r_d = snap_r_q;
    win_end = en && (timer_q == LAST);
    nxt_l = (spike_left && cnt_l_q != MAXC) ? cnt_l_q + 1'b1 : cnt_l_q;
    nxt_r = (spike_right && cnt_r_q != MAXC) ? cnt_r_q + 1'b1 : cnt_r_q;
    if (en) begin
      if (win_end) begin
        snap_l_d = nxt_l;
        snap_r_d = nxt_r;
        cnt_l_d = '0;
        cnt_r_d = '0;
        timer_d = '0;
      end else begin
        cnt_l_d = nxt_l;
        cnt_r_d = nxt_r;
        timer_d = timer_q + 1'b1;
      end
    end
  end

  // Rate comparison on the snapshot, one bit wider to avoid overflow.
  always_comb begin
    diff = $signed({1'b0, snap_l_q}) - $signed({1'b0, snap_r_q});
    abs_diff = diff[CW] ? $unsigned(-diff) : $unsigned(diff);
    if ({1'b0, snap_l_q} < (CW+1)'(MIN_RATE) &&
        {1'b0, snap_r_q} < (CW+1)'(MIN_RATE)) begin
      dec_cmd = C_STOP;
    end else if (abs_diff <= (CW+1)'(DEADBAND)) begin
      dec_cmd = C_FWD;
    end else if (snap_l_q > snap_r_q) begin
      dec_cmd = C_LEFT;
    end else begin
      dec_cmd = C_RIGHT;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (win_end) state_d = EVAL;
             else if (en) state_d = COUNT;
      COUNT: if (win_end) state_d = EVAL;
      EVAL:  state_d = OUT;
      OUT:   if (win_end) state_d = EVAL;
             else if (hs) state_d = COUNT;
      default: state_d = IDLE;
    endcase
  end

  // Result registers, valid flag and sticky overrun.
  always_comb begin
    left_rate_d = left_rate_q;
    right_rate_d = right_rate_q;
    cmd_d = cmd_q;
    cmd_valid_d = cmd_valid_q;
    overrun_d = overrun_q;
    unique case (state_q)
      EVAL: begin
        left_rate_d = snap_l_q;
        right_rate_d = snap_r_q;
        cmd_d = dec_cmd;
        cmd_valid_d = 1'b1;
      end
      OUT: begin
        if (hs) cmd_valid_d = 1'b0;
        if (win_end && !hs) overrun_d = 1'b1;
      end
      default: ;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      timer_q <= '0;
      cnt_l_q <= '0;
      cnt_r_q <= '0;
      snap_l_q <= '0;
      snap_r_q <= '0;
      left_rate_q <= '0;
      right_rate_q <= '0;
      cmd_q <= C_STOP;
      cmd_valid_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      cnt_l_q <= cnt_l_d;
      cnt_r_q <= cnt_r_d;
      snap_l_q <= snap_l_d;
      snap_r_q <= snap_r_d;
      left_rate_q <= left_rate_d;
      right_rate_q <= right_rate_d;
      cmd_q <= cmd_d;
      cmd_valid_q <= cmd_valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign cmd_valid = cmd_valid_q;
  assign cmd = cmd_q;
  assign left_rate = left_rate_q;
  assign right_rate = right_rate_q;
  assign overrun = overrun_q;

endmodule

// File: tb/tb_spike_motor_decoder.sv
// Bench for spike_motor_decoder: two instances (CW=9 and CW=4)
// share stimulus; a window-level model feeds a scoreboard queue.
module tb_spike_motor_decoder;

  localparam int WL = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic en = 1'b0;
  logic sl = 1'b0;
  logic sr = 1'b0;
  logic rdy = 1'b0;

  logic       v0, v1, ov0, ov1;
  logic [1:0] c0, c1;
  logic [8:0] lr0, rr0;
  logic [3:0] lr1, rr1;

  always #5 clk = ~clk;

  spike_motor_decoder #(
    .WIN_LEN(WL), .CW(9), .DEADBAND(4), .MIN_RATE(2)
  ) u0 (
    .clk(clk), .rst(rst), .en(en),
    .spike_left(sl), .spike_right(sr), .cmd_ready(rdy),
    .cmd_valid(v0), .cmd(c0), .left_rate(lr0),
    .right_rate(rr0), .overrun(ov0)
  );

  spike_motor_decoder #(
    .WIN_LEN(WL), .CW(4), .DEADBAND(4), .MIN_RATE(2)
  ) u1 (
    .clk(clk), .rst(rst), .en(en),
    .spike_left(sl), .spike_right(sr), .cmd_ready(rdy),
    .cmd_valid(v1), .cmd(c1), .left_rate(lr1),
    .right_rate(rr1), .overrun(ov1)
  );

  typedef struct {
    int vis;
    int l;
    int r;
    int c;
  } res_t;

  res_t q0[$];
  res_t q1[$];
  int rd0 = 0;
  int rd1 = 0;
  int cyc = 0;
  int checks = 0;
  int errors = 0;

  int cl[2], cr[2], tm[2], wl[2], wr[2];
  int hl[2], hr[2], hc[2];
  bit ev[2], eo[2], wp[2];
  int mx[2] = '{511, 15};

  // Command from rates: STOP, then FORWARD, then LEFT/RIGHT.
  function automatic int decode(int l, int r);
    int d;
    d = l - r;
    if (d < 0) d = -d;
    if (l < 2 && r < 2) return 0;
    if (d <= 4) return 3;
    if (l > r) return 1;
    return 2;
  endfunction

  // Window-level reference model, stepped on each rising edge.
  always @(posedge clk) begin
    cyc++;
    for (int d = 0; d < 2; d++) begin
      bit vo;
      bit we;
      int nl;
      int nr;
      res_t e;
      if (!rst) begin
        cl[d] = 0; cr[d] = 0; tm[d] = 0;
        ev[d] = 0; eo[d] = 0; wp[d] = 0;
        hl[d] = 0; hr[d] = 0; hc[d] = 0;
      end else begin
        vo = ev[d];
        we = 0;
        if (wp[d]) begin
          ev[d] = 1;
          hl[d] = wl[d];
          hr[d] = wr[d];
          hc[d] = decode(wl[d], wr[d]);
          e.vis = cyc; e.l = hl[d]; e.r = hr[d]; e.c = hc[d];
          if (d == 0) q0.push_back(e);
          else q1.push_back(e);
        end else if (vo && rdy) begin
          ev[d] = 0;
        end
        if (en) begin
          nl = cl[d] + int'(sl);
          nr = cr[d] + int'(sr);
          if (nl > mx[d]) nl = mx[d];
          if (nr > mx[d]) nr = mx[d];
          if (tm[d] == WL - 1) begin
            we = 1;
            wl[d] = nl; wr[d] = nr;
            cl[d] = 0; cr[d] = 0; tm[d] = 0;
          end else begin
            cl[d] = nl; cr[d] = nr;
            tm[d] = tm[d] + 1;
          end
        end
        if (we && vo && !rdy) eo[d] = 1;
        wp[d] = we;
      end
    end
  end

  task automatic chk(input int d, input logic v, input int c,
                     input int l, input int r, input logic o);
    res_t e;
    int n;
    checks++;
    if (v !== ev[d]) begin
      errors++;
      $display("FAIL valid[%0d] cyc %0d got %0b want %0b", d, cyc, v, ev[d]);
    end
    checks++;
    if (o !== eo[d]) begin
      errors++;
      $display("FAIL overrun[%0d] cyc %0d got %0b want %0b", d, cyc, o, eo[d]);
    end
    checks++;
    if (c != hc[d] || l != hl[d] || r != hr[d]) begin
      errors++;
      $display("FAIL hold[%0d] cyc %0d got c%0d L%0d R%0d want c%0d L%0d R%0d",
               d, cyc, c, l, r, hc[d], hl[d], hr[d]);
    end
    n = (d == 0) ? q0.size() : q1.size();
    while (((d == 0) ? rd0 : rd1) < n) begin
      if (d == 0) begin
        e = q0[rd0]; rd0++;
      end else begin
        e = q1[rd1]; rd1++;
      end
      checks++;
      if (e.vis != cyc || v !== 1'b1 || c != e.c || l != e.l || r != e.r) begin
        errors++;
        $display("FAIL result[%0d] cyc %0d got v%0b c%0d L%0d R%0d want @%0d c%0d L%0d R%0d",
                 d, cyc, v, c, l, r, e.vis, e.c, e.l, e.r);
      end
    end
  endtask

  // Monitor: compares both instances away from the active edge.
  always @(negedge clk) begin
    chk(0, v0, int'(c0), int'(lr0), int'(rr0), ov0);
    chk(1, v1, int'(c1), int'(lr1), int'(rr1), ov1);
  end

  task automatic drive(input int n, input bit e, input bit l,
                       input bit r, input bit rd_i, input bit rs = 1'b1);
    repeat (n) begin
      @(negedge clk);
      rst = rs; en = e; sl = l; sr = r; rdy = rd_i;
    end
  endtask

  task automatic window(input int nl, input int nr, input bit rd_i);
    for (int i = 0; i < WL; i++) begin
      @(negedge clk);
      rst = 1'b1; en = 1'b1;
      sl = (i < nl); sr = (i < nr); rdy = rd_i;
    end
  endtask

  initial begin
    int pl;
    int pr;
    int pk;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      rst = 1'b0; en = 1'b1; rdy = 1'b1;
      sl = i[0]; sr = ~i[0];
    end
    window(0, 0, 1'b0);
    drive(3, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 1);
    drive(2, 0, 0, 0, 0);
    window(16, 0, 1'b1);
    drive(4, 0, 0, 0, 1);
    window(5, 9, 1'b1);
    drive(4, 0, 0, 0, 1);
    window(3, 8, 1'b1);
    drive(4, 0, 0, 0, 1);
    window(1, 1, 1'b1);
    drive(4, 0, 0, 0, 1);
    window(16, 0, 1'b0);
    window(0, 16, 1'b0);
    drive(3, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 1);
    drive(3, 0, 0, 0, 0);
    drive(8, 1, 1, 0, 1);
    drive(10, 0, 1, 1, 1);
    drive(8, 1, 1, 0, 1);
    drive(4, 0, 0, 0, 1);
    window(16, 0, 1'b0);
    drive(3, 0, 0, 0, 0);
    drive(1, 1, 1, 1, 1, 1'b0);
    drive(3, 0, 0, 0, 0);
    pl = 50; pr = 50; pk = 1;
    for (int i = 0; i < 3000; i++) begin
      if (i % 64 == 0) begin
        pl = $urandom_range(0, 100);
        pr = $urandom_range(0, 100);
        pk = $urandom_range(0, 3);
      end
      @(negedge clk);
      rst = ($urandom_range(0, 399) != 0);
      en = ($urandom_range(0, 3) != 0);
      sl = ($urandom_range(0, 99) < pl);
      sr = ($urandom_range(0, 99) < pr);
      rdy = ($urandom_range(0, 3) < pk);
    end
    drive(6, 0, 0, 0, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
